// File: rtl/mem_pkg.sv
// mem_pkg: shared types and constants for the memory access sequencer.
//   state_e        - sequencer states
//   WORD_W         - datapath / RAM word width
//   ADDR_WORDS_DEF - default number of implemented RAM words
//   addr_in_range  - unsigned full-width range test (no wrap-around)
package mem_pkg;

  localparam int WORD_W         = 32;
  localparam int ADDR_WORDS_DEF = 512;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

  // True when addr addresses an implemented word; compared on all 32 bits.
  function automatic logic addr_in_range(input logic [WORD_W-1:0] addr,
                                         input logic [WORD_W-1:0] limit);
    return (addr < limit);
  endfunction

endpackage

// File: rtl/mem_access_ctrl_mdr_mux_reg.sv
// mdr_mux_reg: memory data register with a load select between the datapath
// bus and the RAM read port. A RAM load wins over a bus load.
//   clock, reset_n     - clock, async active-low reset
//   load_bus, bus_in   - load from datapath bus
//   load_ram, ram_q    - load from RAM read data
//   q                  - register contents
module mdr_mux_reg
  import mem_pkg::*;
(
  input  logic              clock,
  input  logic              reset_n,
  input  logic              load_bus,
  input  logic              load_ram,
  input  logic [WORD_W-1:0] bus_in,
  input  logic [WORD_W-1:0] ram_q,
  output logic [WORD_W-1:0] q
);

  logic [WORD_W-1:0] q_q;
  logic [WORD_W-1:0] q_d;

  // Next-value select.
  always_comb begin
    q_d = q_q;
    if (load_ram) begin
      q_d = ram_q;
    end else if (load_bus) begin
      q_d = bus_in;
    end else begin
      q_d = q_q;
    end
  end

  // Register with async clear.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      q_q <= {WORD_W{1'b0}};
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: MAR/MDR holder and RAM access sequencer. Turns one-cycle
// rd_req/wr_req pulses into registered RAM strobes that span at least one
// full negedge (where the RAM samples), returns read data into the MDR and
// signals completion with a one-cycle done pulse.
//   clock, reset_n            - clock, async active-low reset
//   bus_in, mar_in, mdr_in    - datapath bus and register load enables
//   rd_req, wr_req            - access requests (ignored while busy)
//   mdr_out                   - MDR contents
//   busy, done, addr_err      - status (addr_err is sticky until reset)
//   ram_addr, ram_data        - RAM address (MAR) and write data (MDR)
//   ram_read, ram_write       - registered RAM strobes
//   ram_q                     - RAM read data
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_WORDS  = ADDR_WORDS_DEF,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [WORD_W-1:0] bus_in,
  input  logic              mar_in,
  input  logic              mdr_in,
  input  logic              rd_req,
  input  logic              wr_req,
  output logic [WORD_W-1:0] mdr_out,
  output logic              busy,
  output logic              done,
  output logic              addr_err,
  output logic [WORD_W-1:0] ram_addr,
  output logic [WORD_W-1:0] ram_data,
  output logic              ram_read,
  output logic              ram_write,
  input  logic [WORD_W-1:0] ram_q
);

  localparam logic [WORD_W-1:0] LIMIT     = WORD_W'(ADDR_WORDS);
  localparam logic [2:0]        WAIT_LAST = 3'(WAIT_CYCLES);

  state_e            state_q, state_d;
  logic              op_wr_q, op_wr_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] mar_q, mar_d;
  logic              err_q, err_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              mdr_load_bus_s;
  logic              mdr_load_ram_s;
  logic [WORD_W-1:0] mdr_s;

  mdr_mux_reg u_mdr (
    .clock    (clock),
    .reset_n  (reset_n),
    .load_bus (mdr_load_bus_s),
    .load_ram (mdr_load_ram_s),
    .bus_in   (bus_in),
    .ram_q    (ram_q),
    .q        (mdr_s)
  );

  // Next-state, register loads and next values of the registered outputs.
  always_comb begin
    state_d        = state_q;
    op_wr_d        = op_wr_q;
    cnt_d          = cnt_q;
    mar_d          = mar_q;
    err_d          = err_q;
    mdr_load_bus_s = 1'b0;
    mdr_load_ram_s = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (mar_in) begin
          mar_d = bus_in;
        end else begin
          mar_d = mar_q;
        end
        mdr_load_bus_s = mdr_in;
        // The request uses the MAR value held before this edge.
        if (rd_req && wr_req) begin
          err_d = 1'b1;
        end else if (rd_req || wr_req) begin
          if (addr_in_range(mar_q, LIMIT)) begin
            state_d = ST_ACCESS;
            op_wr_d = wr_req;
            cnt_d   = 3'd0;
          end else begin
            // Out of range: report completion without touching the RAM.
            err_d   = 1'b1;
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACCESS: begin
        if (cnt_q == WAIT_LAST) begin
          state_d = ST_CAPTURE;
          // ram_q settled at the last strobe negedge; latch it on the
          // edge that enters CAPTURE.
          mdr_load_ram_s = !op_wr_q;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      ST_CAPTURE: begin
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    rd_d   = (state_d == ST_ACCESS) && !op_wr_d;
    wr_d   = (state_d == ST_ACCESS) && op_wr_d;
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // State, MAR and registered outputs; reset drops strobes immediately.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      op_wr_q <= 1'b0;
      cnt_q   <= 3'd0;
      mar_q   <= {WORD_W{1'b0}};
      err_q   <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_wr_q <= op_wr_d;
      cnt_q   <= cnt_d;
      mar_q   <= mar_d;
      err_q   <= err_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign mdr_out   = mdr_s;
  assign busy      = busy_q;
  assign done      = done_q;
  assign addr_err  = err_q;
  assign ram_addr  = mar_q;
  assign ram_data  = mdr_s;
  assign ram_read  = rd_q;
  assign ram_write = wr_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

  logic clock = 1'b0;
  logic reset_n = 1'b0;

  // DUT with default timing
  logic [31:0] bus_in = 32'd0;
  logic mar_in = 1'b0, mdr_in = 1'b0, rd_req = 1'b0, wr_req = 1'b0;
  logic [31:0] mdr_out, ram_addr, ram_data;
  logic [31:0] ram_q = 32'd0;
  logic busy, done, addr_err, ram_read, ram_write;

  // DUT with WAIT_CYCLES = 2
  logic [31:0] w_bus_in = 32'd0;
  logic w_mar_in = 1'b0, w_mdr_in = 1'b0, w_rd_req = 1'b0, w_wr_req = 1'b0;
  logic [31:0] w_mdr_out, w_ram_addr, w_ram_data;
  logic [31:0] w_ram_q = 32'd0;
  logic w_busy, w_done, w_addr_err, w_ram_read, w_ram_write;

  int total = 0;
  int passed = 0;

  // Behavioural model of memory/registers for DUT 0
  logic [31:0] ref_mem [0:511];
  logic [31:0] ref_mdr = 32'd0;
  logic        ref_err = 1'b0;

  // RAM models (negedge sampling)
  logic [31:0] mem0 [0:511];
  bit          wr0  [0:511];
  logic [31:0] mem2 [0:511];
  bit          wr2  [0:511];

  always #5 clock = ~clock;

  mem_access_ctrl dut0 (
    .clock(clock), .reset_n(reset_n), .bus_in(bus_in), .mar_in(mar_in), .mdr_in(mdr_in),
    .rd_req(rd_req), .wr_req(wr_req), .mdr_out(mdr_out), .busy(busy), .done(done),
    .addr_err(addr_err), .ram_addr(ram_addr), .ram_data(ram_data), .ram_read(ram_read),
    .ram_write(ram_write), .ram_q(ram_q));

  mem_access_ctrl #(.ADDR_WORDS(512), .WAIT_CYCLES(2)) dut2 (
    .clock(clock), .reset_n(reset_n), .bus_in(w_bus_in), .mar_in(w_mar_in), .mdr_in(w_mdr_in),
    .rd_req(w_rd_req), .wr_req(w_wr_req), .mdr_out(w_mdr_out), .busy(w_busy), .done(w_done),
    .addr_err(w_addr_err), .ram_addr(w_ram_addr), .ram_data(w_ram_data), .ram_read(w_ram_read),
    .ram_write(w_ram_write), .ram_q(w_ram_q));

  function automatic logic [31:0] init_word(input int unsigned i);
    if (i == 133) return 32'd16;
    else if (i == 138) return 32'd12;
    else return (i * 32'h0100_0193) ^ 32'hA5A5_0F0F;
  endfunction

  always @(negedge clock) begin
    if (ram_write && ram_addr < 32'd512) begin
      mem0[ram_addr[8:0]] <= ram_data;
      wr0[ram_addr[8:0]]  <= 1'b1;
    end
    if (ram_read && ram_addr < 32'd512)
      ram_q <= wr0[ram_addr[8:0]] ? mem0[ram_addr[8:0]] : init_word(ram_addr);
  end

  always @(negedge clock) begin
    if (w_ram_write && w_ram_addr < 32'd512) begin
      mem2[w_ram_addr[8:0]] <= w_ram_data;
      wr2[w_ram_addr[8:0]]  <= 1'b1;
    end
    if (w_ram_read && w_ram_addr < 32'd512)
      w_ram_q <= wr2[w_ram_addr[8:0]] ? mem2[w_ram_addr[8:0]] : init_word(w_ram_addr);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input bit sel, input bit is_mdr, input logic [31:0] val);
    if (sel) begin
      w_bus_in = val; w_mar_in = !is_mdr; w_mdr_in = is_mdr;
    end else begin
      bus_in = val; mar_in = !is_mdr; mdr_in = is_mdr;
    end
    tick();
    w_mar_in = 1'b0; w_mdr_in = 1'b0; mar_in = 1'b0; mdr_in = 1'b0;
  endtask

  // Pulse a request and observe the access until done (bounded).
  task automatic issue(input bit sel, input logic rd, input logic wr,
                       output int n_strobe, output int n_busy, output int done_at,
                       output logic [31:0] s_addr, output logic [31:0] s_data,
                       output logic s_wr, output logic [31:0] done_mdr);
    if (sel) begin w_rd_req = rd; w_wr_req = wr; end
    else begin rd_req = rd; wr_req = wr; end
    tick();
    rd_req = 1'b0; wr_req = 1'b0; w_rd_req = 1'b0; w_wr_req = 1'b0;
    n_strobe = 0; n_busy = 0; done_at = 0;
    s_addr = 32'd0; s_data = 32'd0; s_wr = 1'b0; done_mdr = 32'd0;
    for (int c = 1; c <= 12; c++) begin
      if (sel ? (w_ram_read || w_ram_write) : (ram_read || ram_write)) begin
        n_strobe++;
        s_addr = sel ? w_ram_addr : ram_addr;
        s_data = sel ? w_ram_data : ram_data;
        s_wr   = sel ? w_ram_write : ram_write;
      end
      if (sel ? w_busy : busy) n_busy++;
      if (sel ? w_done : done) begin
        done_at = c;
        done_mdr = sel ? w_mdr_out : mdr_out;
        break;
      end
      tick();
    end
    if (done_at != 0) tick();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    ref_mdr = 32'd0; ref_err = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if ({mdr_out, busy, done, addr_err, ram_addr, ram_data, ram_read, ram_write} !== 100'd0)
      $display("FAIL reset_dut0: got mdr=%h busy=%b done=%b err=%b addr=%h data=%h rd=%b wr=%b, expected all 0",
               mdr_out, busy, done, addr_err, ram_addr, ram_data, ram_read, ram_write);
    else passed++;
    total++;
    if ({w_mdr_out, w_busy, w_done, w_addr_err, w_ram_addr, w_ram_data, w_ram_read, w_ram_write} !== 100'd0)
      $display("FAIL reset_dut2: outputs not all 0 (mdr=%h addr=%h)", w_mdr_out, w_ram_addr);
    else passed++;
  endtask

  task automatic test_read_133();
    int ns, nb, da; logic [31:0] sa, sd, dm; logic sw;
    load(1'b0, 1'b0, 32'd133);
    issue(1'b0, 1'b1, 1'b0, ns, nb, da, sa, sd, sw, dm);
    ref_mdr = 32'd16;
    total++;
    if (ns != 1 || sw !== 1'b0 || sa !== 32'd133)
      $display("FAIL read133_strobe: got cycles=%0d wr=%b addr=%0d, expected 1 read of 133", ns, sw, sa);
    else passed++;
    total++;
    if (da != 3 || nb != 3)
      $display("FAIL read133_timing: got done_at=%0d busy=%0d, expected 3/3", da, nb);
    else passed++;
    total++;
    if (dm !== 32'd16)
      $display("FAIL read133_data: got %h expected %h", dm, 32'd16);
    else passed++;
  endtask

  task automatic test_write_90();
    int ns, nb, da; logic [31:0] sa, sd, dm; logic sw;
    load(1'b0, 1'b0, 32'd90);
    load(1'b0, 1'b1, 32'd85);
    issue(1'b0, 1'b0, 1'b1, ns, nb, da, sa, sd, sw, dm);
    ref_mem[90] = 32'd85;
    total++;
    if (ns != 1 || sw !== 1'b1 || sa !== 32'd90 || sd !== 32'd85 || da != 3)
      $display("FAIL write90: got cycles=%0d wr=%b addr=%0d data=%0d done_at=%0d, expected 1/1/90/85/3",
               ns, sw, sa, sd, da);
    else passed++;
    load(1'b0, 1'b1, 32'd0);
    issue(1'b0, 1'b1, 1'b0, ns, nb, da, sa, sd, sw, dm);
    ref_mdr = ref_mem[90];
    total++;
    if (dm !== 32'd85)
      $display("FAIL readback90: got %0d expected 85", dm);
    else passed++;
  endtask

  task automatic test_out_of_range();
    int ns, nb, da; logic [31:0] sa, sd, dm; logic sw;
    load(1'b0, 1'b1, 32'h0000_1234);
    load(1'b0, 1'b0, 32'd600);
    issue(1'b0, 1'b1, 1'b0, ns, nb, da, sa, sd, sw, dm);
    ref_err = 1'b1; ref_mdr = 32'h0000_1234;
    total++;
    if (ns != 0 || da != 1 || addr_err !== 1'b1)
      $display("FAIL oor600: got strobes=%0d done_at=%0d err=%b, expected 0/1/1", ns, da, addr_err);
    else passed++;
    total++;
    if (mdr_out !== ref_mdr)
      $display("FAIL oor600_mdr: got %h expected %h", mdr_out, ref_mdr);
    else passed++;
    load(1'b0, 1'b0, 32'd133);
    issue(1'b0, 1'b1, 1'b0, ns, nb, da, sa, sd, sw, dm);
    ref_mdr = ref_mem[133];
    total++;
    if (addr_err !== 1'b1 || dm !== ref_mdr)
      $display("FAIL err_sticky: got err=%b mdr=%h, expected 1/%h", addr_err, dm, ref_mdr);
    else passed++;
  endtask

  task automatic test_conflict();
    int ns, nb, da, got; logic [31:0] sa, sd, dm; logic sw;
    do_reset();
    load(1'b0, 1'b0, 32'd133);
    issue(1'b0, 1'b1, 1'b1, ns, nb, da, sa, sd, sw, dm);
    ref_err = 1'b1;
    total++;
    if (ns != 0 || da != 0 || nb != 0 || addr_err !== 1'b1)
      $display("FAIL conflict: got strobes=%0d done_at=%0d busy=%0d err=%b, expected 0/0/0/1", ns, da, nb, addr_err);
    else passed++;
    // MAR load attempted while busy must be ignored.
    load(1'b0, 1'b0, 32'd10);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
    bus_in = 32'd5; mar_in = 1'b1;
    tick();
    mar_in = 1'b0;
    got = 0;
    for (int c = 0; c < 10; c++) begin
      if (done) begin got = 1; break; end
      tick();
    end
    tick();
    ref_mdr = ref_mem[10];
    total++;
    if (got != 1 || ram_addr !== 32'd10 || mdr_out !== ref_mdr)
      $display("FAIL busy_ignore: got done=%0d mar=%0d mdr=%h, expected 1/10/%h", got, ram_addr, mdr_out, ref_mdr);
    else passed++;
  endtask

  task automatic test_wait2();
    int ns, nb, da; logic [31:0] sa, sd, dm; logic sw;
    load(1'b1, 1'b0, 32'd138);
    issue(1'b1, 1'b1, 1'b0, ns, nb, da, sa, sd, sw, dm);
    total++;
    if (ns != 3 || da != 5 || nb != 5 || dm !== 32'd12)
      $display("FAIL wait2_read138: got strobes=%0d done_at=%0d busy=%0d mdr=%0d, expected 3/5/5/12", ns, da, nb, dm);
    else passed++;
    load(1'b1, 1'b0, 32'd300);
    load(1'b1, 1'b1, 32'h0000_55AA);
    issue(1'b1, 1'b0, 1'b1, ns, nb, da, sa, sd, sw, dm);
    load(1'b1, 1'b1, 32'd0);
    issue(1'b1, 1'b1, 1'b0, ns, nb, da, sa, sd, sw, dm);
    total++;
    if (dm !== 32'h0000_55AA || w_addr_err !== 1'b0)
      $display("FAIL wait2_wr_rd300: got mdr=%h err=%b, expected 000055aa/0", dm, w_addr_err);
    else passed++;
  endtask

  task automatic test_back_to_back();
    int ns, nb, da; logic [31:0] sa, sd, dm; logic sw;
    load(1'b0, 1'b0, 32'd200);
    load(1'b0, 1'b1, 32'hCAFE_F00D);
    issue(1'b0, 1'b0, 1'b1, ns, nb, da, sa, sd, sw, dm);
    ref_mem[200] = 32'hCAFE_F00D;
    // Next request on the first idle cycle after done.
    issue(1'b0, 1'b1, 1'b0, ns, nb, da, sa, sd, sw, dm);
    ref_mdr = ref_mem[200];
    total++;
    if (ns != 1 || da != 3 || dm !== ref_mdr)
      $display("FAIL back_to_back: got strobes=%0d done_at=%0d mdr=%h, expected 1/3/%h", ns, da, dm, ref_mdr);
    else passed++;
  endtask

  task automatic test_reset_mid_write();
    int ns, nb, da; logic [31:0] sa, sd, dm, word; logic sw;
    load(1'b0, 1'b0, 32'd175);
    load(1'b0, 1'b1, 32'hDEAD_BEEF);
    wr_req = 1'b1;
    tick();
    wr_req = 1'b0;
    total++;
    if (ram_write !== 1'b1)
      $display("FAIL rst_mid_strobe_on: got ram_write=%b expected 1", ram_write);
    else passed++;
    reset_n = 1'b0;
    #1;
    total++;
    if ({mdr_out, busy, done, addr_err, ram_addr, ram_data, ram_read, ram_write} !== 100'd0)
      $display("FAIL rst_mid_outputs: got wr=%b busy=%b mar=%h mdr=%h, expected all 0", ram_write, busy, ram_addr, mdr_out);
    else passed++;
    tick(); tick();
    reset_n = 1'b1;
    tick();
    ref_mdr = 32'd0; ref_err = 1'b0;
    word = wr0[175] ? mem0[175] : init_word(175);
    total++;
    if (word !== ref_mem[175])
      $display("FAIL rst_mid_ram175: got %h expected %h", word, ref_mem[175]);
    else passed++;
    load(1'b0, 1'b0, 32'd175);
    issue(1'b0, 1'b1, 1'b0, ns, nb, da, sa, sd, sw, dm);
    ref_mdr = ref_mem[175];
    total++;
    if (dm !== ref_mdr)
      $display("FAIL rst_mid_read175: got %h expected %h", dm, ref_mdr);
    else passed++;
  endtask

  task automatic test_random();
    int ns, nb, da, sel_a, exp_ns, exp_da; logic [31:0] sa, sd, dm, addr, data; logic sw, is_wr, in_rng;
    for (int n = 0; n < 40; n++) begin
      sel_a = int'($urandom_range(0, 7));
      case (sel_a)
        0: addr = 32'd511;
        1: addr = 32'd512;
        2: addr = 32'hFFFF_FFFF;
        3: addr = 32'd512 + $urandom_range(0, 100000);
        default: addr = $urandom_range(0, 511);
      endcase
      is_wr = 1'($urandom_range(0, 1));
      data = $urandom;
      load(1'b0, 1'b0, addr);
      load(1'b0, 1'b1, data);
      issue(1'b0, !is_wr, is_wr, ns, nb, da, sa, sd, sw, dm);
      in_rng = (addr < 32'd512);
      if (in_rng) begin
        exp_ns = 1; exp_da = 3;
        if (is_wr) begin ref_mem[addr[8:0]] = data; ref_mdr = data; end
        else ref_mdr = ref_mem[addr[8:0]];
      end else begin
        exp_ns = 0; exp_da = 1; ref_err = 1'b1; ref_mdr = data;
      end
      total++;
      if (ns != exp_ns || da != exp_da || (in_rng && (sa !== addr || sw !== is_wr)))
        $display("FAIL rand%0d_access: addr=%h wr=%b got strobes=%0d done_at=%0d saddr=%h swr=%b, expected %0d/%0d",
                 n, addr, is_wr, ns, da, sa, sw, exp_ns, exp_da);
      else passed++;
      total++;
      if (mdr_out !== ref_mdr || addr_err !== ref_err)
        $display("FAIL rand%0d_state: addr=%h got mdr=%h err=%b, expected %h/%b", n, addr, mdr_out, addr_err, ref_mdr, ref_err);
      else passed++;
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = init_word(i);
    test_reset();
    test_read_133();
    test_write_90();
    test_out_of_range();
    test_conflict();
    test_wait2();
    test_back_to_back();
    test_reset_mid_write();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
